bf_mem_arbiter: RTL
===================

BF_MEM_ARBITER -- requirements
Module: bf_mem_arbiter

Interface
REQ-001 Parameter i_addr_width, default 16: instruction-port address width.
REQ-002 Parameter d_addr_width, default 8: data-port address width.
REQ-003 Parameter m_addr_width, default 16: unified memory address width; SHALL be >= i_addr_width and >= d_addr_width.
REQ-004 Parameter d_base, default 16'h8000: unified-memory base of the data space.
REQ-005 Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request (read only).
- i_addr  in  i_addr_width  fetch address.
- i_ack  out  1  fetch acknowledge.
- i_rdata  out  8  fetch data.
- d_req  in  1  data request.
- d_dir  in  1  data direction, 0=read, 1=write.
- d_addr  in  d_addr_width  data address.
- d_wdata  in  8  data write value.
- d_ack  out  1  data acknowledge.
- d_rdata  out  8  data read value.
- m_req  out  1  memory request.
- m_dir  out  1  memory direction, 0=read, 1=write.
- m_addr  out  m_addr_width  memory address.
- m_wdata  out  8  memory write value.
- m_ack  in  1  memory acknowledge.
- m_rdata  in  8  memory read data.
- grant_d  out  1  1 while the current/last transaction belongs to the data port.

Function
REQ-006 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-007 Every port uses a four-phase handshake: req held with stable address/data until ack=1; ack held until req=0; ack then drops.
REQ-008 FSM states: IDLE, ISSUE, RESP, DRAIN.
REQ-009 IDLE: with m_ack=0 and at least one req=1, select a winner, latch its address/dir/wdata, set m_req=1, go ISSUE; m_req SHALL be high in the cycle after the edge that sampled req.
REQ-010 IDLE with m_ack=1 (stale) SHALL NOT issue; requests wait until m_ack=0.
REQ-011 Arbitration: single requester wins; if both request, the port not granted last wins (round-robin); the last-grant flag updates on every issue.
REQ-012 Instruction issue: m_dir=0, m_addr=i_addr zero-extended, m_wdata unchanged.
REQ-013 Data issue: m_dir=d_dir, m_wdata=d_wdata, m_addr=(d_base + zero-extended d_addr) mod 2^m_addr_width.
REQ-014 ISSUE: on m_ack=1, capture m_rdata into the granted port's rdata (reads only; write leaves rdata unchanged), set the granted port's ack=1, go RESP.
REQ-015 RESP: when the granted req=0, set ack=0 and m_req=0, go DRAIN; ack stays high while req stays high.
REQ-016 DRAIN: when m_ack=0, go IDLE; the next arbitration occurs no earlier than the following cycle.
REQ-017 The non-granted port's ack SHALL remain 0 at all times.
REQ-018 m_addr/m_dir/m_wdata SHALL stay constant from issue until leaving RESP.
REQ-019 Requester drops req before ack (protocol violation): memory transaction still completes; ack SHALL NOT assert; RESP step is skipped (m_req=0 on m_ack, go DRAIN).
REQ-020 Starvation bound: a held request SHALL be issued after at most one transaction of the other port.
REQ-021 rdata outputs SHALL hold their last captured value until the next read completion for that port.

Reset
REQ-022 rst=1 at a rising edge SHALL force state=IDLE, m_req=0, i_ack=0, d_ack=0, grant_d=0, last-grant=data (instruction wins first tie), m_dir=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0.
REQ-023 Reset mid-transaction SHALL abandon it immediately; after reset, no issue occurs while m_ack=1 (REQ-010).

Verification
REQ-024 i_req=1, i_addr=16'h0012; memory acks after 3 cycles with 8'h2B -> m_req high 1 cycle after req, m_addr=16'h0012, m_dir=0, i_ack=1 with i_rdata=8'h2B, d_ack stays 0.
REQ-025 d_req=1, d_dir=1, d_addr=8'h05, d_wdata=8'hA7 -> m_addr=16'h8005, m_dir=1, m_wdata=8'hA7, d_ack=1, d_rdata unchanged.
REQ-026 i_req and d_req asserted same cycle after reset, both re-requesting continuously -> grant order I, D, I, D; grant_d tracks 0,1,0,1.
REQ-027 d_base=16'hFFF0, d_addr=8'h20 -> m_addr=16'h0010 (wrap).
REQ-028 rst pulsed while in ISSUE with m_ack=1 held 2 more cycles, i_req held -> all outputs 0 next cycle; new issue only after m_ack=0.
REQ-029 d_req dropped before m_ack -> transaction completes, d_ack never asserts, FSM returns to IDLE and serves pending i_req.

Source files
------------

// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter
// Shares one byte-wide memory port between an instruction-fetch port and a
// data port. All three ports use a four-phase req/ack handshake. When both
// ports ask at once, the port that was not granted last time wins. The data
// port is mapped into unified memory at offset d_base.
module bf_mem_arbiter #(
  parameter int i_addr_width = 16,
  parameter int d_addr_width = 8,
  parameter int m_addr_width = 16,
  parameter logic [m_addr_width-1:0] d_base = 16'h8000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [i_addr_width-1:0] i_addr,
  output logic                    i_ack,
  output logic [7:0]              i_rdata,
  input  logic                    d_req,
  input  logic                    d_dir,
  input  logic [d_addr_width-1:0] d_addr,
  input  logic [7:0]              d_wdata,
  output logic                    d_ack,
  output logic [7:0]              d_rdata,
  output logic                    m_req,
  output logic                    m_dir,
  output logic [m_addr_width-1:0] m_addr,
  output logic [7:0]              m_wdata,
  input  logic                    m_ack,
  input  logic [7:0]              m_rdata,
  output logic                    grant_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

  state_t                  state, state_nx;
  logic                    last_d, last_d_nx;
  logic                    m_req_nx, m_dir_nx, i_ack_nx, d_ack_nx, grant_d_nx;
  logic [m_addr_width-1:0] m_addr_nx;
  logic [7:0]              m_wdata_nx, i_rdata_nx, d_rdata_nx;
  logic                    win_d;
  logic                    gnt_req;

  // Next-state and next-output logic; every register holds its value unless a
  // state transition says otherwise, so outputs only change on clock edges.
  always_comb begin
    state_nx   = state;
    last_d_nx  = last_d;
    m_req_nx   = m_req;
    m_dir_nx   = m_dir;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    i_ack_nx   = i_ack;
    d_ack_nx   = d_ack;
    i_rdata_nx = i_rdata;
    d_rdata_nx = d_rdata;
    grant_d_nx = grant_d;
    // Data wins if it is the only requester, or on a tie when instruction had the last grant.
    win_d      = d_req && (!i_req || !last_d);
    gnt_req    = grant_d ? d_req : i_req;
    case (state)
      IDLE: begin
        // A lingering m_ack from an abandoned transaction blocks new issues.
        if (!m_ack && (i_req || d_req)) begin
          state_nx   = ISSUE;
          m_req_nx   = 1'b1;
          grant_d_nx = win_d;
          last_d_nx  = win_d;
          if (win_d) begin
            m_dir_nx   = d_dir;
            m_addr_nx  = d_base + m_addr_width'(d_addr);
            m_wdata_nx = d_wdata;
          end else begin
            m_dir_nx  = 1'b0;
            m_addr_nx = m_addr_width'(i_addr);
          end
        end
      end
      ISSUE: begin
        if (m_ack) begin
          if (gnt_req) begin
            state_nx = RESP;
            if (grant_d) begin
              d_ack_nx = 1'b1;
              if (!m_dir) d_rdata_nx = m_rdata;
            end else begin
              i_ack_nx   = 1'b1;
              i_rdata_nx = m_rdata;
            end
          end else begin
            // Requester gave up early: finish the memory cycle without acking.
            state_nx = DRAIN;
            m_req_nx = 1'b0;
          end
        end
      end
      RESP: begin
        if (!gnt_req) begin
          state_nx = DRAIN;
          m_req_nx = 1'b0;
          i_ack_nx = 1'b0;
          d_ack_nx = 1'b0;
        end
      end
      DRAIN: begin
        if (!m_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; last grant resets to
  // data so the instruction port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      m_req   <= 1'b0;
      m_dir   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      grant_d <= 1'b0;
    end else begin
      state   <= state_nx;
      last_d  <= last_d_nx;
      m_req   <= m_req_nx;
      m_dir   <= m_dir_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      i_ack   <= i_ack_nx;
      d_ack   <= d_ack_nx;
      i_rdata <= i_rdata_nx;
      d_rdata <= d_rdata_nx;
      grant_d <= grant_d_nx;
    end
  end

endmodule
